// File: rtl/fpmul_pkg.sv
// rtl/fpmul_pkg.sv - shared state encoding and FP constants for the FpMul arbiter
package fpmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [1:0]  RM_NEAREST = 2'b00;
    localparam logic [1:0]  RM_ZERO    = 2'b01;

endpackage

// File: rtl/fpmul_arbiter_rr_picker.sv
// rtl/fpmul_arbiter_rr_picker.sv - combinational round-robin priority encoder (module rr_picker)
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    // Scan from the farthest offset down to ptr so the nearest requester at or after ptr wins.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_any = 1'b1;
                o_idx = PW'((int'(i_ptr) + k) % N);
            end
        end
        o_grant = o_any ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// rtl/fpmul_arbiter.sv - round-robin sharing of one FpMul between N_REQ requesters; FPMUL_ARB_TIMEOUT_EN adds a WAIT watchdog
module fpmul_arbiter
    import fpmul_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int D_LEN          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*D_LEN-1:0] req_a,
    input  logic [N_REQ*D_LEN-1:0] req_b,
    input  logic [N_REQ*2-1:0]     req_rmode,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [D_LEN-1:0]       rsp_data,
    output logic                   busy,
    output logic                   mul_start,
    output logic [D_LEN-1:0]       mul_a,
    output logic [D_LEN-1:0]       mul_b,
    output logic [1:0]             mul_round_mode,
    input  logic [D_LEN-1:0]       mul_result,
    input  logic                   mul_done
`ifdef FPMUL_ARB_TIMEOUT_EN
    ,
    output logic                   err_timeout
`endif
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             r_state;
    logic [PW-1:0]      r_rr_ptr;
    logic [PW-1:0]      r_owner;
    logic               r_busy;
    logic               r_mul_start;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [D_LEN-1:0]   r_rsp_data;
    logic [D_LEN-1:0]   r_mul_a;
    logic [D_LEN-1:0]   r_mul_b;
    logic [1:0]         r_mul_rmode;

    logic [N_REQ-1:0]   w_grant;
    logic [PW-1:0]      w_idx;
    logic               w_any;

`ifdef FPMUL_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WW-1:0]      r_wdog;
    logic               r_err_timeout;
    assign err_timeout = r_err_timeout;
`endif

    rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Accept strobe is offered only while idle and never while reset is held.
    assign req_ready      = (r_state == IDLE && rst_n) ? w_grant : '0;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign busy           = r_busy;
    assign mul_start      = r_mul_start;
    assign mul_a          = r_mul_a;
    assign mul_b          = r_mul_b;
    assign mul_round_mode = r_mul_rmode;

    // Sequencer: grant -> one start pulse -> wait for done -> hold response until owner accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_busy      <= 1'b0;
            r_mul_start <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_rmode <= '0;
`ifdef FPMUL_ARB_TIMEOUT_EN
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            r_mul_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_mul_a     <= req_a[w_idx*D_LEN +: D_LEN];
                        r_mul_b     <= req_b[w_idx*D_LEN +: D_LEN];
                        r_mul_rmode <= req_rmode[w_idx*2 +: 2];
                        r_owner     <= w_idx;
                        r_mul_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef FPMUL_ARB_TIMEOUT_EN
                    r_wdog  <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (mul_done) begin
                        r_rsp_data  <= mul_result;
                        r_rsp_valid <= N_REQ'(1) << r_owner;
                        r_state     <= RESP;
                    end
`ifdef FPMUL_ARB_TIMEOUT_EN
                    else if (r_wdog == WW'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_data    <= D_LEN'(FP_QNAN);
                        r_rsp_valid   <= N_REQ'(1) << r_owner;
                        r_err_timeout <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_rr_ptr    <= (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// tb/tb_fpmul_arbiter.sv - directed self-checking bench for fpmul_arbiter with a behavioural FpMul
module tb_fpmul_arbiter;

    localparam int N   = 4;
    localparam int D   = 32;
    localparam int TO  = 16;
    localparam int LAT = 3;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*D-1:0] req_a;
    logic [N*D-1:0] req_b;
    logic [N*2-1:0] req_rmode;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [D-1:0]   rsp_data;
    logic           busy;
    logic           mul_start;
    logic [D-1:0]   mul_a;
    logic [D-1:0]   mul_b;
    logic [1:0]     mul_round_mode;
    logic [D-1:0]   mul_result;
    logic           mul_done;
`ifdef FPMUL_ARB_TIMEOUT_EN
    logic           err_timeout;
`endif

    fpmul_arbiter #(.N_REQ(N), .D_LEN(D), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_rmode      (req_rmode),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .busy           (busy),
        .mul_start      (mul_start),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_round_mode (mul_round_mode),
        .mul_result     (mul_result),
        .mul_done       (mul_done)
`ifdef FPMUL_ARB_TIMEOUT_EN
        ,
        .err_timeout    (err_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Hand-computed IEEE-754 products for the operand pairs the bench uses.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000) return b;
        if (a == 32'h40200000 && b == 32'h40600000) return 32'h410C0000;
        if (a == 32'hBFC00000 && b == 32'h40000000) return 32'hC0400000;
        return 32'hDEADBEEF;
    endfunction

    // Behavioural FpMul: fixed latency after start, reset from the same net.
    bit       done_en = 1'b1;
    logic [2:0]  m_cnt;
    logic [31:0] m_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt      <= '0;
            m_res      <= '0;
            mul_done   <= 1'b0;
            mul_result <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_start) begin
                m_cnt <= 3'(LAT);
                m_res <= fp_model(mul_a, mul_b);
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1'b1;
                if (m_cnt == 1 && done_en) begin
                    mul_done   <= 1'b1;
                    mul_result <= m_res;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        req_a[i*D +: D]   = a;
        req_b[i*D +: D]   = b;
        req_rmode[i*2 +: 2] = rm;
    endtask

    task automatic wait_rsp(input int bound, output int starts);
        starts = 0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (mul_start) starts++;
            if (rsp_valid != 0) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_rsp: no rsp_valid within %0d cycles", bound);
    endtask

    task automatic release_rsp(input int i, input string tag);
        rsp_ready[i] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[i] = 1'b0;
        @(negedge clk);
        check({tag, ".busy_after"}, 32'(busy), 32'd0);
        check({tag, ".rsp_valid_after"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd0);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".rsp_data"}, rsp_data, 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".mul_start"}, 32'(mul_start), 32'd0);
        check({tag, ".mul_a"}, mul_a, 32'd0);
        check({tag, ".mul_b"}, mul_b, 32'd0);
        check({tag, ".mul_rmode"}, 32'(mul_round_mode), 32'd0);
`ifdef FPMUL_ARB_TIMEOUT_EN
        check({tag, ".err_timeout"}, 32'(err_timeout), 32'd0);
`endif
    endtask

    // Called at a negedge with the arbiter idle; returns at a negedge with it idle again.
    task automatic do_single(input int i, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] rm, input logic [31:0] exp, input string tag);
        int st;
        set_req(i, a, b, rm);
        req_valid[i] = 1'b1;
        #1 check({tag, ".req_ready"}, 32'(req_ready), 32'(N'(1) << i));
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        wait_rsp(40, st);
        check({tag, ".starts"}, 32'(st), 32'd1);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(N'(1) << i));
        check({tag, ".rsp_data"}, rsp_data, exp);
        check({tag, ".mul_a"}, mul_a, a);
        check({tag, ".mul_b"}, mul_b, b);
        check({tag, ".mul_rmode"}, 32'(mul_round_mode), 32'(rm));
        release_rsp(i, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int st;
        logic [N-1:0] got;
        logic [31:0]  held;

        tbl[0] = '{0, 32'h40200000, 32'h40600000, 2'b00, 32'h410C0000};
        tbl[1] = '{1, 32'hBFC00000, 32'h40000000, 2'b01, 32'hC0400000};
        tbl[2] = '{2, 32'h3F800000, 32'h12345678, 2'b00, 32'h12345678};
        tbl[3] = '{3, 32'h3F800000, 32'hC1200000, 2'b01, 32'hC1200000};
        tbl[4] = '{0, 32'h3F800000, 32'h7F800000, 2'b10, 32'h7F800000};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_rmode = '0;
        rsp_ready = '0;

        // Reset state, including req_ready gated while reset is held.
        repeat (2) @(negedge clk);
        req_valid = 4'b1111;
        #1 check_all_zero("reset");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention: req0 and req1 together; req0 first, req1 after req0's response.
        set_req(0, 32'hBFC00000, 32'h40000000, 2'b00);
        set_req(1, 32'hBFC00000, 32'h40000000, 2'b00);
        req_valid = 4'b0011;
        #1 check("cont.ready0", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("cont.ready_issue", 32'(req_ready), 32'h0);
        check("cont.start", 32'(mul_start), 32'h1);
        check("cont.busy", 32'(busy), 32'h1);
        wait_rsp(40, st);
        check("cont.rsp_valid0", 32'(rsp_valid), 32'h1);
        check("cont.rsp_data0", rsp_data, 32'hC0400000);
        check("cont.ready_resp", 32'(req_ready), 32'h0);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;
        @(negedge clk);
        check("cont.ready1", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_rsp(40, st);
        check("cont.rsp_valid1", 32'(rsp_valid), 32'h2);
        check("cont.rsp_data1", rsp_data, 32'hC0400000);
        release_rsp(1, "cont.r1");

        // Single-op vectors.
        for (int v = 0; v < 5; v++)
            do_single(tbl[v].idx, tbl[v].a, tbl[v].b, tbl[v].rm, tbl[v].exp, $sformatf("vec%0d", v));

        // Fairness: all four requesting continuously for 8 ops after reset.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'h3F800000, 32'h40400000 + i, 2'(i & 1));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            for (int c = 0; c < 20 && req_ready == 0; c++) @(negedge clk);
            got = req_ready;
            check($sformatf("fair.grant%0d", k), 32'(got), 32'(N'(1) << (k % N)));
            @(posedge clk);
            wait_rsp(40, st);
            check($sformatf("fair.rsp_valid%0d", k), 32'(rsp_valid), 32'(got));
            check($sformatf("fair.rsp_data%0d", k), rsp_data, 32'h40400000 + (k % N));
            rsp_ready = got;
            @(posedge clk);
            #1 rsp_ready = '0;
            if (k == 7) req_valid = '0;
            @(negedge clk);
        end

        // Backpressure: owner withholds rsp_ready; non-owner ready and request are ignored.
        set_req(2, 32'h3F800000, 32'h41000000, 2'b01);
        req_valid = 4'b0100;
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(40, st);
        check("bp.rsp_valid", 32'(rsp_valid), 32'h4);
        check("bp.rsp_data", rsp_data, 32'h41000000);
        held = rsp_data;
        set_req(1, 32'h3F800000, 32'h3F000000, 2'b00);
        req_valid = 4'b0010;
        rsp_ready = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp.rsp_valid%0d", c), 32'(rsp_valid), 32'h4);
            check($sformatf("bp.rsp_data%0d", c), rsp_data, held);
            check($sformatf("bp.req_ready%0d", c), 32'(req_ready), 32'h0);
            check($sformatf("bp.start%0d", c), 32'(mul_start), 32'h0);
        end
        req_valid = '0;
        rsp_ready = '0;
        release_rsp(2, "bp");

        // Reset pulsed during WAIT clears everything; the next op completes normally.
        set_req(3, 32'h3F800000, 32'h40A00000, 2'b01);
        req_valid = 4'b1000;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst.busy_wait", 32'(busy), 32'h1);
        check("rst.rsp_valid_wait", 32'(rsp_valid), 32'h0);
        rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rst.idle%0d", c), 32'({busy, rsp_valid}), 32'h0);
        end
        do_single(3, 32'h3F800000, 32'h40A00000, 2'b01, 32'h40A00000, "rst.after");

`ifdef FPMUL_ARB_TIMEOUT_EN
        // Watchdog: no done -> qNaN response and sticky error flag.
        done_en = 1'b0;
        set_req(0, 32'h40200000, 32'h40600000, 2'b00);
        req_valid = 4'b0001;
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(TO + 20, st);
        check("to.rsp_valid", 32'(rsp_valid), 32'h1);
        check("to.rsp_data", rsp_data, 32'h7FC00000);
        check("to.err", 32'(err_timeout), 32'h1);
        release_rsp(0, "to");
        done_en = 1'b1;
        do_single(0, 32'h40200000, 32'h40600000, 2'b00, 32'h410C0000, "to.after");
        check("to.err_sticky", 32'(err_timeout), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
